encoder83_seq: RTL and testbench

ENCODER83_SEQ -- requirements
Module: encoder83_seq

---
 rtl/encoder83_seq_if.sv | 38 +++
 rtl/encoder83_seq.sv | 146 ++++++++++++++
 tb/tb_encoder83_seq.sv | 201 ++++++++++++++++++++
 3 files changed

// File: rtl/encoder83_seq_if.sv
// encoder83_seq_if -- request/grant bundle for the sequential 8-to-3 encoder.
// master: the requester/consumer side (drives req and ready).
// slave : the encoder (drives code, valid, pend and, when ENCODER83_MULTI_EN
//         is defined, multi).
interface encoder83_seq_if;
  logic [7:0] req;
  logic [2:0] code;
  logic       valid;
  logic       ready;
  logic [7:0] pend;
`ifdef ENCODER83_MULTI_EN
  logic       multi;
`endif

  modport master (
    output req,
    output ready,
    input  code,
    input  valid,
    input  pend
`ifdef ENCODER83_MULTI_EN
    ,
    input  multi
`endif
  );

  modport slave (
    input  req,
    input  ready,
    output code,
    output valid,
    output pend
`ifdef ENCODER83_MULTI_EN
    ,
    output multi
`endif
  );
endinterface

// File: rtl/encoder83_seq.sv
// encoder83_seq -- sequential priority encoder with sticky pending requests
// and a valid/ready grant handshake.
// Requests are latched into a sticky pending vector; an idle/grant FSM picks
// the highest-priority pending bit (PRIO_HIGH=1: bit 7 wins, 0: bit 0 wins),
// holds the code stable until the consumer accepts it, then clears that bit.
// A request arriving in the same cycle its bit is cleared keeps the bit set.
// Optional feature: define ENCODER83_MULTI_EN to add the multi output, which
// flags that more than one request was pending when the grant was issued.
module encoder83_seq #(
  parameter int PRIO_HIGH = 1
) (
  input  logic           clk,
  input  logic           rst,
  encoder83_seq_if.slave bus
);

  typedef enum logic [0:0] {
    IDLE  = 1'b0,
    GRANT = 1'b1
  } state_t;

  state_t     state_r;
  state_t     state_nx_s;
  logic [7:0] pend_r;
  logic [7:0] pend_nx_s;
  logic [7:0] clr_s;
  logic [2:0] code_r;
  logic [2:0] code_nx_s;
  logic       valid_r;
  logic       valid_nx_s;
  logic       hs_s;
`ifdef ENCODER83_MULTI_EN
  logic       multi_r;
  logic       multi_nx_s;
`endif

  // Index of the winning set bit; later loop iterations override earlier
  // ones, so the scan direction decides which end of the vector wins.
  function automatic logic [2:0] prio_enc(input logic [7:0] vec);
    logic [2:0] idx;
    idx = 3'd0;
    for (int k = 0; k < 8; k++) begin
      if (PRIO_HIGH != 0) begin
        if (vec[3'(k)]) begin
          idx = 3'(k);
        end else begin
          idx = idx;
        end
      end else begin
        if (vec[3'(7 - k)]) begin
          idx = 3'(7 - k);
        end else begin
          idx = idx;
        end
      end
    end
    return idx;
  endfunction

`ifdef ENCODER83_MULTI_EN
  // True when two or more bits of the vector are set.
  function automatic logic more_than_one(input logic [7:0] vec);
    logic [3:0] cnt;
    cnt = 4'd0;
    for (int k = 0; k < 8; k++) begin
      cnt = cnt + {3'b000, vec[3'(k)]};
    end
    return (cnt > 4'd1);
  endfunction
`endif

  // Pending-vector update: clear the accepted code, then OR in new requests
  // so a same-cycle request re-arms the bit.
  always_comb begin
    hs_s      = valid_r & bus.ready;
    clr_s     = hs_s ? (8'h01 << code_r) : 8'h00;
    pend_nx_s = (pend_r & ~clr_s) | bus.req;
  end

  // Grant FSM next state; code (and multi) only reload on IDLE -> GRANT.
  always_comb begin
    state_nx_s = state_r;
    code_nx_s  = code_r;
    valid_nx_s = valid_r;
`ifdef ENCODER83_MULTI_EN
    multi_nx_s = multi_r;
`endif
    case (state_r)
      IDLE: begin
        if (pend_r != 8'h00) begin
          state_nx_s = GRANT;
          code_nx_s  = prio_enc(pend_r);
          valid_nx_s = 1'b1;
`ifdef ENCODER83_MULTI_EN
          multi_nx_s = more_than_one(pend_r);
`endif
        end else begin
          state_nx_s = IDLE;
          valid_nx_s = 1'b0;
        end
      end
      GRANT: begin
        if (bus.ready) begin
          state_nx_s = IDLE;
          valid_nx_s = 1'b0;
        end else begin
          state_nx_s = GRANT;
          valid_nx_s = 1'b1;
        end
      end
      default: begin
        state_nx_s = IDLE;
        valid_nx_s = 1'b0;
      end
    endcase
  end

  // State and output registers; reset discards any grant and all pending bits.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_r <= IDLE;
      pend_r  <= 8'h00;
      code_r  <= 3'd0;
      valid_r <= 1'b0;
`ifdef ENCODER83_MULTI_EN
      multi_r <= 1'b0;
`endif
    end else begin
      state_r <= state_nx_s;
      pend_r  <= pend_nx_s;
      code_r  <= code_nx_s;
      valid_r <= valid_nx_s;
`ifdef ENCODER83_MULTI_EN
      multi_r <= multi_nx_s;
`endif
    end
  end

  assign bus.code  = code_r;
  assign bus.valid = valid_r;
  assign bus.pend  = pend_r;
`ifdef ENCODER83_MULTI_EN
  assign bus.multi = multi_r;
`endif

endmodule

// File: tb/tb_encoder83_seq.sv
// tb_encoder83_seq -- directed bench for encoder83_seq.
// Two instances: u_hi (PRIO_HIGH=1) takes every stimulus step, u_lo
// (PRIO_HIGH=0) only sees the 8'h81 pulse. Inputs change and outputs are
// checked at the falling edge, half a period away from the active edge.
// multi checks are active only when ENCODER83_MULTI_EN is defined.
module tb_encoder83_seq;

  logic clk;
  logic rst;
  int   n_cmp;
  int   n_err;

  encoder83_seq_if if_hi ();
  encoder83_seq_if if_lo ();

  encoder83_seq #(.PRIO_HIGH(1)) u_hi (.clk(clk), .rst(rst), .bus(if_hi.slave));
  encoder83_seq #(.PRIO_HIGH(0)) u_lo (.clk(clk), .rst(rst), .bus(if_lo.slave));

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [7:0] obs, input logic [7:0] exp);
    n_cmp++;
    assert (obs === exp) else begin
      n_err++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic chk_hi(input string tag, input logic v, input logic [2:0] c, input logic [7:0] p);
    chk({tag, ".valid"}, 8'(if_hi.valid), 8'(v));
    chk({tag, ".code"},  8'(if_hi.code),  8'(c));
    chk({tag, ".pend"},  if_hi.pend,      p);
  endtask

  task automatic chk_multi_hi(input string tag, input logic m);
`ifdef ENCODER83_MULTI_EN
    chk({tag, ".multi"}, 8'(if_hi.multi), 8'(m));
`else
    if (m === 1'bx) $display("unused %s", tag);
`endif
  endtask

  task automatic chk_multi_lo(input string tag, input logic m);
`ifdef ENCODER83_MULTI_EN
    chk({tag, ".lo_multi"}, 8'(if_lo.multi), 8'(m));
`else
    if (m === 1'bx) $display("unused %s", tag);
`endif
  endtask

  task automatic nxt();
    @(negedge clk);
  endtask

  initial begin
    logic [7:0] exp_pend;
    n_cmp = 0;
    n_err = 0;
    rst = 1'b1;
    if_hi.req = 8'h00;
    if_hi.ready = 1'b0;
    if_lo.req = 8'h00;
    if_lo.ready = 1'b1;
    nxt();
    nxt();
    // reset state
    chk_hi("reset", 1'b0, 3'd0, 8'h00);
    chk_multi_hi("reset", 1'b0);
    chk("reset.lo_valid", 8'(if_lo.valid), 8'h00);
    rst = 1'b0;

    // single request 8'h20, ready high
    if_hi.req = 8'h20;
    if_hi.ready = 1'b1;
    nxt();
    chk_hi("r20.e1", 1'b0, 3'd0, 8'h20);
    if_hi.req = 8'h00;
    nxt();
    chk_hi("r20.e2", 1'b1, 3'd5, 8'h20);
    nxt();
    chk_hi("r20.e3", 1'b0, 3'd5, 8'h00);
    nxt();
    chk_hi("r20.idle_hold", 1'b0, 3'd5, 8'h00);

    // 8'h81 pulse: high priority 7 then 0, low priority 0 then 7
    if_hi.req = 8'h81;
    if_lo.req = 8'h81;
    nxt();
    chk_hi("r81.e1", 1'b0, 3'd5, 8'h81);
    if_hi.req = 8'h00;
    if_lo.req = 8'h00;
    nxt();
    chk_hi("r81.g1", 1'b1, 3'd7, 8'h81);
    chk_multi_hi("r81.g1", 1'b1);
    chk("r81.lo_g1.valid", 8'(if_lo.valid), 8'h01);
    chk("r81.lo_g1.code",  8'(if_lo.code),  8'h00);
    chk_multi_lo("r81.lo_g1", 1'b1);
    nxt();
    chk_hi("r81.gap", 1'b0, 3'd7, 8'h01);
    chk("r81.lo_gap.pend", if_lo.pend, 8'h80);
    nxt();
    chk_hi("r81.g2", 1'b1, 3'd0, 8'h01);
    chk_multi_hi("r81.g2", 1'b0);
    chk("r81.lo_g2.valid", 8'(if_lo.valid), 8'h01);
    chk("r81.lo_g2.code",  8'(if_lo.code),  8'h07);
    chk_multi_lo("r81.lo_g2", 1'b0);
    nxt();
    chk_hi("r81.done", 1'b0, 3'd0, 8'h00);
    chk("r81.lo_done.pend", if_lo.pend, 8'h00);

    // grant code 2 stalled with ready low while 8'h80 arrives
    if_hi.ready = 1'b0;
    if_hi.req = 8'h04;
    nxt();
    chk_hi("stall.e1", 1'b0, 3'd0, 8'h04);
    if_hi.req = 8'h00;
    nxt();
    chk_hi("stall.g", 1'b1, 3'd2, 8'h04);
    chk_multi_hi("stall.g", 1'b0);
    if_hi.req = 8'h80;
    nxt();
    chk_hi("stall.h0", 1'b1, 3'd2, 8'h84);
    if_hi.req = 8'h00;
    for (int i = 0; i < 3; i++) begin
      nxt();
      chk_hi("stall.hold", 1'b1, 3'd2, 8'h84);
    end
    if_hi.ready = 1'b1;
    nxt();
    chk_hi("stall.acc", 1'b0, 3'd2, 8'h80);
    nxt();
    chk_hi("stall.g7", 1'b1, 3'd7, 8'h80);
    nxt();
    chk_hi("stall.done", 1'b0, 3'd7, 8'h00);

    // req[3] held: code 3 every two cycles
    if_hi.req = 8'h08;
    nxt();
    chk_hi("held.e1", 1'b0, 3'd7, 8'h08);
    for (int i = 0; i < 3; i++) begin
      nxt();
      chk_hi("held.g", 1'b1, 3'd3, 8'h08);
      nxt();
      chk_hi("held.i", 1'b0, 3'd3, 8'h08);
    end
    if_hi.req = 8'h00;
    nxt();
    chk_hi("held.last", 1'b1, 3'd3, 8'h08);
    nxt();
    chk_hi("held.done", 1'b0, 3'd3, 8'h00);

    // all eight lines at once: 8 grants in 16 cycles, strict order
    if_hi.req = 8'hFF;
    nxt();
    chk_hi("all.e1", 1'b0, 3'd3, 8'hFF);
    if_hi.req = 8'h00;
    exp_pend = 8'hFF;
    for (int k = 7; k >= 0; k--) begin
      nxt();
      chk_hi("all.g", 1'b1, 3'(k), exp_pend);
      chk_multi_hi("all.g", (k != 0));
      exp_pend[k] = 1'b0;
      nxt();
      chk_hi("all.i", 1'b0, 3'(k), exp_pend);
    end

    // asynchronous reset in the middle of a grant, pend = 8'hF0
    if_hi.ready = 1'b0;
    if_hi.req = 8'hF0;
    nxt();
    if_hi.req = 8'h00;
    nxt();
    chk_hi("arst.g", 1'b1, 3'd7, 8'hF0);
    chk_multi_hi("arst.g", 1'b1);
    #2;
    rst = 1'b1;
    #1;
    chk_hi("arst.now", 1'b0, 3'd0, 8'h00);
    chk_multi_hi("arst.now", 1'b0);
    #1;
    rst = 1'b0;
    nxt();
    chk_hi("arst.after", 1'b0, 3'd0, 8'h00);

    // first grant after reset keeps the normal latency
    if_hi.req = 8'h02;
    if_hi.ready = 1'b1;
    nxt();
    chk_hi("post.e1", 1'b0, 3'd0, 8'h02);
    if_hi.req = 8'h00;
    nxt();
    chk_hi("post.g", 1'b1, 3'd1, 8'h02);
    nxt();
    chk_hi("post.done", 1'b0, 3'd1, 8'h00);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
